// File: rtl/strobe_sequencer.sv
// Frame sequencer: walks the latched channel requests issuing setup/strobe/hold
// phases per channel, then a read strobe once Enable is released.
module strobe_sequencer #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned SETUP   = 1,
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned HOLD    = 1
) (
    input  logic                      Clock_1us,
    input  logic                      Rst,
    input  logic                      Enable,
    input  logic [N_CH-1:0]           ch_req,
    output logic [N_CH-1:0]           strobe,
    output logic [$clog2(N_CH)-1:0]   sel,
    output logic                      sel_valid,
    output logic                      rd_strobe,
    output logic                      frame_done,
    output logic                      aborted,
    output logic                      busy,
    output logic [2:0]                state
);

    localparam int unsigned SW    = $clog2(N_CH);
    localparam int unsigned MAX_A = (SETUP > PULSE_W) ? SETUP : PULSE_W;
    localparam int unsigned MAXD  = (MAX_A > HOLD) ? MAX_A : HOLD;
    localparam int unsigned CW    = $clog2(MAXD) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_LOW = 3'd4,
        ST_READ     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [N_CH-1:0]   rem_c;
    logic              last_c;
    logic              chan_end_c;
    logic              abort_c;

    logic [N_CH-1:0]   strobe_d;
    logic              sel_valid_d;
    logic              rd_strobe_d;
    logic              frame_done_d;
    logic              aborted_d;
    logic              busy_d;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [SW-1:0] lowest_idx(input logic [N_CH-1:0] m);
        logic [SW-1:0] idx;
        logic          found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (m[i] && !found) begin
                idx   = SW'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Phase length loaded on entry to each timed state.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        logic [CW-1:0] len;
        case (s)
            ST_SETUP:           len = CW'(SETUP);
            ST_STROBE, ST_READ: len = CW'(PULSE_W);
            ST_HOLD:            len = CW'(HOLD);
            default:            len = CW'(1);
        endcase
        return len;
    endfunction

    // State and datapath registers.
    always_ff @(posedge Clock_1us or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state, phase counter and request mask.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        sel_d      = sel_q;
        chan_end_c = 1'b0;
        abort_c    = 1'b0;
        rem_c      = mask_q & ~(N_CH'(1) << sel_q);
        last_c     = (cnt_q <= CW'(1));

        if (cnt_q > CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    mask_d = ch_req;
                    if (ch_req == '0) begin
                        state_d = ST_WAIT_LOW;
                    end else begin
                        state_d = ST_SETUP;
                        sel_d   = lowest_idx(ch_req);
                    end
                end
            end
            ST_SETUP: begin
                if (last_c) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (last_c) begin
                    if (HOLD != 0) state_d = ST_HOLD;
                    else           chan_end_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (last_c) chan_end_c = 1'b1;
            end
            ST_WAIT_LOW: begin
                if (!Enable) state_d = ST_READ;
            end
            ST_READ: begin
                if (last_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Retire the current channel and jump straight to the next requested one.
        if (chan_end_c) begin
            mask_d = rem_c;
            if ((rem_c != '0) && Enable) begin
                state_d = ST_SETUP;
                sel_d   = lowest_idx(rem_c);
            end else begin
                state_d = ST_WAIT_LOW;
                abort_c = (rem_c != '0);
            end
        end

        if (state_d != state_q) begin
            cnt_d = phase_len(state_d);
        end
    end

    // Output values decoded from the next state so every output leaves a flop.
    always_comb begin
        strobe_d = '0;
        if (state_d == ST_STROBE) begin
            strobe_d[sel_d] = 1'b1;
        end
        sel_valid_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        rd_strobe_d  = (state_d == ST_READ);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_WAIT_LOW) && (state_q != ST_WAIT_LOW);
        aborted_d    = abort_c;
    end

    // Output registers.
    always_ff @(posedge Clock_1us or posedge Rst) begin
        if (Rst) begin
            strobe     <= '0;
            sel_valid  <= 1'b0;
            rd_strobe  <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            strobe     <= strobe_d;
            sel_valid  <= sel_valid_d;
            rd_strobe  <= rd_strobe_d;
            frame_done <= frame_done_d;
            aborted    <= aborted_d;
            busy       <= busy_d;
        end
    end

    assign sel   = sel_q;
    assign state = state_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed bench for strobe_sequencer with N_CH=4, SETUP=1, PULSE_W=2, HOLD=1.
module tb_strobe_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_STROBE = 3'd2,
                           S_HOLD = 3'd3, S_WAIT = 3'd4, S_READ = 3'd5;

    logic       Clock_1us = 1'b0;
    logic       Rst;
    logic       Enable;
    logic [3:0] ch_req;
    logic [3:0] strobe;
    logic [1:0] sel;
    logic       sel_valid, rd_strobe, frame_done, aborted, busy;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    logic [1:0] last_sel;

    strobe_sequencer #(.N_CH(4), .SETUP(1), .PULSE_W(2), .HOLD(1)) dut (
        .Clock_1us  (Clock_1us),
        .Rst        (Rst),
        .Enable     (Enable),
        .ch_req     (ch_req),
        .strobe     (strobe),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .rd_strobe  (rd_strobe),
        .frame_done (frame_done),
        .aborted    (aborted),
        .busy       (busy),
        .state      (state)
    );

    always #5 Clock_1us = ~Clock_1us;

    task automatic tick();
        @(posedge Clock_1us);
        #1;
    endtask

    // One packed comparison of every output: {state,strobe,sel,sel_valid,rd,fd,ab,busy}.
    task automatic expect_out(input string tag, input logic [2:0] st, input logic [3:0] stb,
                              input logic [1:0] sl, input logic sv, input logic rd,
                              input logic fd, input logic ab, input logic bz);
        logic [13:0] obs, exp;
        obs = {state, strobe, sel, sel_valid, rd_strobe, frame_done, aborted, busy};
        exp = {st, stb, sl, sv, rd, fd, ab, bz};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (state,strobe,sel,sv,rd,fd,ab,busy)", tag, obs, exp);
        end
    endtask

    // One serviced channel: SETUP, two STROBE cycles, HOLD.
    task automatic chan(input string tag, input int c);
        logic [3:0] oh;
        logic [1:0] s;
        oh = 4'(1 << c);
        s  = 2'(c);
        tick(); expect_out({tag, "_setup"},   S_SETUP,  4'h0, s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out({tag, "_strobe1"}, S_STROBE, oh,   s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out({tag, "_strobe2"}, S_STROBE, oh,   s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out({tag, "_hold"},    S_HOLD,   4'h0, s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        last_sel = s;
    endtask

    // Enable already low or dropped here: two READ cycles then IDLE.
    task automatic read_tail(input string tag);
        Enable = 1'b0;
        tick(); expect_out({tag, "_rd1"},  S_READ, 4'h0, last_sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); expect_out({tag, "_rd2"},  S_READ, 4'h0, last_sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); expect_out({tag, "_idle"}, S_IDLE, 4'h0, last_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Rst      = 1'b1;
        Enable   = 1'b0;
        ch_req   = 4'h0;
        last_sel = 2'd0;
        tick(); tick();
        expect_out("reset", S_IDLE, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        tick();
        expect_out("idle_no_enable", S_IDLE, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full frame over all four channels.
        ch_req = 4'b1111;
        Enable = 1'b1;
        chan("full_c0", 0);
        chan("full_c1", 1);
        chan("full_c2", 2);
        chan("full_c3", 3);
        tick(); expect_out("full_done", S_WAIT, 4'h0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("full_wait", S_WAIT, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("full_wait2", S_WAIT, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_tail("full");

        // Sparse request: channels 1 and 3 only, back to back.
        ch_req = 4'b1010;
        Enable = 1'b1;
        chan("sparse_c1", 1);
        chan("sparse_c3", 3);
        tick(); expect_out("sparse_done", S_WAIT, 4'h0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        read_tail("sparse");

        // Empty request goes straight to WAIT_LOW.
        ch_req = 4'b0000;
        Enable = 1'b1;
        tick(); expect_out("empty_done", S_WAIT, 4'h0, last_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        read_tail("empty");

        // Abort: Enable drops during channel 1 STROBE.
        ch_req = 4'b1111;
        Enable = 1'b1;
        chan("abort_c0", 0);
        tick(); expect_out("abort_c1_setup",  S_SETUP,  4'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("abort_c1_strobe1", S_STROBE, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        Enable = 1'b0;
        tick(); expect_out("abort_c1_strobe2", S_STROBE, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("abort_c1_hold",   S_HOLD,   4'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("abort_done",      S_WAIT,   4'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        last_sel = 2'd1;
        read_tail("abort");

        // Asynchronous reset during channel 2 STROBE, then a fresh frame.
        ch_req = 4'b1111;
        Enable = 1'b1;
        chan("rst_c0", 0);
        chan("rst_c1", 1);
        tick(); expect_out("rst_c2_setup",  S_SETUP,  4'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("rst_c2_strobe", S_STROBE, 4'h4, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 Rst = 1'b1;
        #1 expect_out("rst_async", S_IDLE, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("rst_held", S_IDLE, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        tick(); expect_out("rst_fresh_setup",  S_SETUP,  4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("rst_fresh_strobe", S_STROBE, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        Enable = 1'b0;
        Rst    = 1'b1;
        tick();
        Rst      = 1'b0;
        last_sel = 2'd0;
        tick(); expect_out("rst_cleanup", S_IDLE, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Request mask is latched at frame start; later ch_req changes are ignored.
        ch_req = 4'b0011;
        Enable = 1'b1;
        tick(); expect_out("latch_c0_setup", S_SETUP, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ch_req = 4'b1100;
        tick(); expect_out("latch_c0_strobe1", S_STROBE, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("latch_c0_strobe2", S_STROBE, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("latch_c0_hold",    S_HOLD,   4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chan("latch_c1", 1);
        tick(); expect_out("latch_done", S_WAIT, 4'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        ch_req = 4'b0000;
        read_tail("latch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/strobe_sequencer.md
Name: strobe_sequencer

Overview:
- Parametrised successor of the fixed display/keyboard/MS6205 write sequencer.
- Runs one frame per Enable assertion over N_CH generic strobe channels: per channel a setup phase with the select index driven, a multi-cycle write strobe, then a hold phase.
- Channels with no pending request are skipped; the requested set is latched at frame start.
- After the frame it waits for Enable low, then issues a read strobe (keyboard-read style) and returns to idle.

Parameters:
- N_CH, 8, number of strobe channels (2..16)
- SETUP, 1, cycles select is stable before strobe rises (>=1)
- PULSE_W, 1, strobe and read-strobe width in cycles (>=1)
- HOLD, 1, cycles select is held after strobe falls (>=0; 0 removes the HOLD state)

Ports:
- Clock_1us  in  1  system clock, all flops on rising edge
- Rst  in  1  asynchronous reset, active-high
- Enable  in  1  frame request level
- ch_req  in  N_CH  per-channel request, sampled only at frame start
- strobe  out  N_CH  one-hot write strobe, registered
- sel  out  clog2(N_CH)  index of the active channel
- sel_valid  out  1  high in SETUP, STROBE and HOLD
- rd_strobe  out  1  read strobe after Enable falls, registered
- frame_done  out  1  one-cycle pulse on entry to WAIT_LOW
- aborted  out  1  one-cycle pulse with frame_done when the frame was cut short
- busy  out  1  high in every state except IDLE
- state  out  3  current state encoding

Behaviour:
- State encodings: IDLE=0, SETUP=1, STROBE=2, HOLD=3, WAIT_LOW=4, READ=5; codes 6 and 7 go to IDLE.
- Every output is a flop output, with no combinational decode glitches on strobe or rd_strobe.
- Rst asserted at any time, including mid-strobe:
  - state=IDLE; strobe, sel, sel_valid, rd_strobe, frame_done, aborted and busy are all 0.
  - The latched request mask and the phase counter are cleared.
- IDLE, Enable sampled 1:
  - Latch mask <= ch_req.
  - If ch_req==0: go to WAIT_LOW and pulse frame_done (aborted=0).
  - Otherwise go to SETUP with sel = lowest set bit of ch_req.
- IDLE, Enable 0: stay in IDLE.
- SETUP lasts SETUP cycles, then STROBE.
- STROBE lasts PULSE_W cycles with strobe[sel]=1 and all other strobe bits 0.
- HOLD lasts HOLD cycles.
- After HOLD (or after STROBE when HOLD=0):
  - Clear mask[sel].
  - If the remaining mask is nonzero and Enable=1, go to SETUP with sel = lowest remaining set bit. Skipped channels cost zero cycles.
  - Otherwise go to WAIT_LOW.
- Channel timing: each serviced channel takes exactly SETUP+PULSE_W+HOLD cycles, back to back. sel changes only on entry to SETUP.
- Enable drops mid-frame:
  - The current channel completes SETUP/STROBE/HOLD; no truncated strobe.
  - Remaining channels are skipped and the block goes to WAIT_LOW.
  - frame_done and aborted pulse together.
  - aborted=1 only if mask bits remained uncleared.
- WAIT_LOW: stay while Enable=1. When Enable is sampled 0, go to READ.
- READ: rd_strobe=1 for PULSE_W cycles, then IDLE.
  - A new frame needs Enable sampled high in IDLE, so each Enable pulse yields at most one frame.
- ch_req changes after the latch are ignored until the next frame.
- Phase counter width is clog2(max(SETUP,PULSE_W,HOLD))+1. It reloads on every state entry and counts down to 1.

Test Plan:
- All tests use N_CH=4, SETUP=1, PULSE_W=2, HOLD=1.
- Full frame: ch_req=4'b1111, Enable high for 20 cycles.
  - strobe runs 0001,0001 / 0010,0010 / 0100,0100 / 1000,1000; each pair is preceded by 1 SETUP cycle and followed by 1 HOLD cycle, so 4 cycles per channel and 16 total.
  - frame_done pulses once and aborted=0.
  - After Enable falls: rd_strobe high exactly 2 cycles, then state=IDLE and busy=0.
- Sparse request: ch_req=4'b1010.
  - Only strobe[1] then strobe[3] are asserted, in 8 cycles total.
  - sel is 1 then 3, never 0 or 2.
- Empty request: ch_req=0, Enable=1.
  - The next cycle is WAIT_LOW with frame_done=1 and no strobe bit asserted.
  - Enable low -> 2-cycle rd_strobe.
- Abort: ch_req=4'b1111, Enable dropped during the STROBE of channel 1.
  - Channel 1 strobe stays high its full 2 cycles and HOLD completes; channels 2 and 3 never strobe.
  - frame_done=aborted=1 on the same cycle, then 2-cycle rd_strobe.
- Reset mid-operation: assert Rst during channel 2 STROBE.
  - In the same cycle (asynchronous), all outputs are 0 and state=0.
  - After release with Enable still high, a fresh frame starts at the lowest requested channel.
- Mask latch: ch_req=4'b0011 at start, changed to 4'b1100 after the first SETUP.
  - Strobes occur only on channels 0 and 1.
